// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: walks an N:1 mux select, streams and captures each bit, then flags a mismatch against the latched word
module mux_scan_sequencer #(
  parameter int N  = 16,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  data_in,
  output logic [SW-1:0] sel,
  input  logic          y_in,
  output logic          ser_out,
  output logic          ser_valid,
  input  logic          ser_ready,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  cap_word,
  output logic          mismatch
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state;
  logic [N-1:0] data_reg;
  logic [N-1:0] cap_nxt;
  if (N > (1 << SW)) begin : g_chk
    $error("N exceeds 2**SW");
  end
  assign busy      = state == SCAN;
  assign ser_valid = state == SCAN;
  assign done      = state == DONE;
  assign ser_out   = ser_valid & y_in;
  always_comb begin
    cap_nxt      = cap_word;
    cap_nxt[sel] = y_in;
  end
  // mismatch compares against cap_nxt so the final bit counts on the DONE-entry edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      cap_word <= '0;
      mismatch <= 1'b0;
      data_reg <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          data_reg <= data_in;
          cap_word <= '0;
          mismatch <= 1'b0;
          sel      <= '0;
          state    <= SCAN;
        end
        SCAN: if (ser_ready) begin
          cap_word <= cap_nxt;
          if (sel == SW'(N-1)) begin
            sel      <= '0;
            mismatch <= cap_nxt != data_reg;
            state    <= DONE;
          end else sel <= sel + 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
